dec38_hold: RTL and testbench
=============================

DEC38_HOLD -- requirements
Module: dec38_hold

Interface
REQ-001 Parameter: HOLD_CYCLES, 8, cycles a decoded code is displayed (legal range 1..255).
REQ-002 Parameter: GAP_CYCLES, 2, blank cycles after each display (legal range 0..255).
REQ-003 Port: i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_en  input  1  decoder enable; low aborts or blocks display.
REQ-006 Port: i_valid  input  1  i_code is valid this cycle.
REQ-007 Port: i_code  input  3  binary code 0..7 to decode.
REQ-008 Port: i_clr  input  1  synchronous clear of o_seen.
REQ-009 Port: o_ready  output  1  block accepts a code this cycle.
REQ-010 Port: o_onehot  output  8  one-hot decode of the held code; 8'h00 when blank.
REQ-011 Port: o_en_flag  output  1  high while a code is displayed.
REQ-012 Port: o_seg  output  8  seven-segment pattern of the held code; 8'hFF when blank.
REQ-013 Port: o_seen  output  8  sticky record of every code displayed since the last clear.

Function
REQ-014 FSM states: IDLE, HOLD, GAP; state, counter, latched code and all outputs are registered.
REQ-015 o_ready shall be 1 only in IDLE with i_en=1; combinational from state and i_en.
REQ-016 Handshake: a code is accepted on an edge where i_valid=1 and o_ready=1; i_valid in any other cycle is ignored, not queued.
REQ-017 On accept: latch i_code, load counter with HOLD_CYCLES-1, enter HOLD.
REQ-018 Latency: outputs show the code from the cycle after the accept edge, for exactly HOLD_CYCLES cycles.
REQ-019 In HOLD: o_onehot = 1 << code, o_en_flag = 1, o_seg = pattern(code).
REQ-020 In HOLD: the counter decrements each cycle; at 0, enter GAP with the counter loaded to GAP_CYCLES-1, or enter IDLE directly if GAP_CYCLES=0.
REQ-021 In GAP: outputs are blank; the counter decrements; at 0, enter IDLE.
REQ-022 Blank means o_onehot=8'h00, o_en_flag=0, o_seg=8'hFF, in IDLE, GAP, and reset.
REQ-023 Segment patterns are active-low with bit order {dp,g,f,e,d,c,b,a}: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8 (hex).
REQ-024 i_en=0 in HOLD or GAP: enter IDLE on the next edge; outputs are blank from the next cycle; no GAP is inserted.
REQ-025 o_seen: the bit for the code is set on the accept edge; i_clr=1 clears it on that edge.
REQ-026 If i_clr and an accept occur on the same edge, o_seen equals only the newly accepted code's bit.
REQ-027 A new accept is possible on the first IDLE cycle after GAP (or HOLD, if GAP_CYCLES=0).
REQ-028 Back-to-back codes are therefore spaced exactly HOLD_CYCLES+GAP_CYCLES+1 cycles apart, accept edge to accept edge.

Reset
REQ-029 i_rst_n=0 shall immediately force IDLE, counter=0, latched code=0, o_seen=8'h00 and blank outputs, independent of i_clk.
REQ-030 Reset asserted mid-HOLD shall blank the outputs asynchronously.
REQ-031 After i_rst_n rises, o_ready=1 on the first cycle if i_en=1.

Verification
REQ-032 Defaults; i_en=1; i_code=5 with i_valid for 1 cycle -> o_onehot=8'h20, o_seg=8'h92, o_en_flag=1 for 8 cycles; then 2 blank cycles; then o_ready=1; o_seen=8'h20.
REQ-033 Codes 0..7 held on i_valid continuously -> each code is displayed for 8 cycles, accepts are 11 cycles apart, and o_seen=8'hFF at the end.
REQ-034 Code 3 accepted; i_en dropped at the 4th HOLD cycle -> blank on the next cycle, IDLE, o_ready=0 until i_en=1 again.
REQ-035 i_rst_n pulled low mid-HOLD with code 7 -> o_onehot=8'h00 and o_seg=8'hFF immediately; o_seen=8'h00.
REQ-036 GAP_CYCLES=0, HOLD_CYCLES=1; codes 1 then 2 -> each code is displayed 1 cycle, accepts are 2 cycles apart, o_onehot sequence 02,00,04.
REQ-037 o_seen=8'h01; i_clr and an accept of code 6 on the same edge -> o_seen=8'h40.

Source files
------------

// File: rtl/dec38_hold.sv
// 3-to-8 decoder with timed display: an accepted code is shown for HOLD_CYCLES,
// followed by GAP_CYCLES blank cycles before the next code can be taken.
module dec38_hold #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_valid,
  input  logic [2:0] i_code,
  input  logic       i_clr,
  output logic       o_ready,
  output logic [7:0] o_onehot,
  output logic       o_en_flag,
  output logic [7:0] o_seg,
  output logic [7:0] o_seen
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic [7:0] onehot_q, onehot_d;
  logic [7:0] seg_q, seg_d;
  logic       en_flag_q, en_flag_d;
  logic [7:0] seen_q, seen_d;
  logic       accept;
  logic       display;

  // Active-low segments, bit order {dp,g,f,e,d,c,b,a}.
  function automatic logic [7:0] seg_pattern(input logic [2:0] c);
    logic [7:0] p;
    case (c)
      3'd0:    p = 8'hC0;
      3'd1:    p = 8'hF9;
      3'd2:    p = 8'hA4;
      3'd3:    p = 8'hB0;
      3'd4:    p = 8'h99;
      3'd5:    p = 8'h92;
      3'd6:    p = 8'h82;
      default: p = 8'hF8;
    endcase
    return p;
  endfunction

  assign o_ready = (state_q == IDLE) && i_en;
  assign accept  = o_ready && i_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    seen_d  = i_clr ? 8'h00 : seen_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          code_d  = i_code;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
          seen_d  = seen_d | (8'h01 << i_code);
        end
      end
      HOLD: begin
        if (!i_en) begin
          state_d = IDLE;
          cnt_d   = 8'h00;
        end else if (cnt_q == 8'h00) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (!i_en || cnt_q == 8'h00) begin
          state_d = IDLE;
          cnt_d   = 8'h00;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'h00;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    display   = (state_d == HOLD);
    onehot_d  = display ? (8'h01 << code_d) : 8'h00;
    seg_d     = display ? seg_pattern(code_d) : 8'hFF;
    en_flag_d = display;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'h00;
      code_q    <= 3'd0;
      onehot_q  <= 8'h00;
      seg_q     <= 8'hFF;
      en_flag_q <= 1'b0;
      seen_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      onehot_q  <= onehot_d;
      seg_q     <= seg_d;
      en_flag_q <= en_flag_d;
      seen_q    <= seen_d;
    end
  end

  assign o_onehot  = onehot_q;
  assign o_seg     = seg_q;
  assign o_en_flag = en_flag_q;
  assign o_seen    = seen_q;

endmodule

// File: tb/tb_dec38_hold.sv
// Bench for dec38_hold: two instances (default timing and HOLD=1/GAP=0) share
// stimulus and are compared every cycle against a timeline-based reference.
module tb_dec38_hold;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       valid = 1'b0;
  logic       clr   = 1'b0;
  logic [2:0] code  = 3'd0;

  logic [1:0] rdy, flag;
  logic [7:0] oh [2];
  logic [7:0] sg [2];
  logic [7:0] sn [2];

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int H [2] = '{8, 1};
  int G [2] = '{2, 0};

  // Reference: display window [lo,hi] and first idle state index, in edge counts.
  int         lo        [2];
  int         hi        [2];
  int         idle_from [2];
  logic [2:0] mcode     [2];
  logic [7:0] mseen     [2];
  bit         acc_last  [2];

  logic [7:0] segtab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  dec38_hold dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .i_code(code), .i_clr(clr),
    .o_ready(rdy[0]), .o_onehot(oh[0]), .o_en_flag(flag[0]), .o_seg(sg[0]), .o_seen(sn[0])
  );

  dec38_hold #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .i_code(code), .i_clr(clr),
    .o_ready(rdy[1]), .o_onehot(oh[1]), .o_en_flag(flag[1]), .o_seg(sg[1]), .o_seen(sn[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    for (int k = 0; k < 2; k++) begin
      bit disp;
      logic [7:0] e_oh, e_sg;
      disp = (n >= lo[k]) && (n <= hi[k]);
      e_oh = disp ? (8'h01 << mcode[k]) : 8'h00;
      e_sg = disp ? segtab[mcode[k]] : 8'hFF;
      chk($sformatf("onehot%0d@%0d", k, n), oh[k], e_oh);
      chk($sformatf("seg%0d@%0d", k, n), sg[k], e_sg);
      chk($sformatf("flag%0d@%0d", k, n), {7'b0, flag[k]}, {7'b0, disp});
      chk($sformatf("seen%0d@%0d", k, n), sn[k], mseen[k]);
    end
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit idle, acc;
      int e;
      idle = (n >= idle_from[k]);
      chk($sformatf("ready%0d@%0d", k, n), {7'b0, rdy[k]}, {7'b0, idle && en});
      e   = n + 1;
      acc = idle && en && valid;
      acc_last[k] = acc;
      if (clr) mseen[k] = 8'h00;
      if (acc) begin
        lo[k]        = e;
        hi[k]        = e + H[k] - 1;
        idle_from[k] = e + H[k] + G[k];
        mcode[k]     = code;
        mseen[k]     = mseen[k] | (8'h01 << code);
      end else if (!idle && !en) begin
        idle_from[k] = e;
        if (hi[k] >= e) hi[k] = e - 1;
      end
    end
    @(posedge clk);
    n++;
    #1;
    chk_outs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      lo[k] = 1; hi[k] = 0; idle_from[k] = 0;
      mcode[k] = 3'd0; mseen[k] = 8'h00;
    end
    chk_outs();
    @(posedge clk); n++;
    @(posedge clk); n++;
    #1;
    chk_outs();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    en = 1'b1;

    // Single code 5
    code = 3'd5; valid = 1'b1;
    step();
    chk("s1_onehot", oh[0], 8'h20);
    chk("s1_seg", sg[0], 8'h92);
    valid = 1'b0;
    repeat (12) step();
    chk("s1_seen", sn[0], 8'h20);

    // Codes 0..7 held valid until each is taken
    for (int c = 0; c < 8; c++) begin
      code = 3'(c); valid = 1'b1;
      acc_last[0] = 1'b0;
      for (int w = 0; w < 20 && !acc_last[0]; w++) step();
      chk($sformatf("s2_accept_code%0d", c), {7'b0, acc_last[0]}, 8'h01);
    end
    valid = 1'b0;
    repeat (12) step();
    chk("s2_seen_all", sn[0], 8'hFF);

    // Code 3, enable dropped during the 4th hold cycle
    code = 3'd3; valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (3) step();
    en = 1'b0;
    step();
    chk("s3_blank", oh[0], 8'h00);
    valid = 1'b1;
    repeat (3) step();
    chk("s3_ready_low", {7'b0, rdy[0]}, 8'h00);
    valid = 1'b0; en = 1'b1;
    step();

    // Async reset in the middle of holding code 7
    code = 3'd7; valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (3) step();
    chk("s4_pre_onehot", oh[0], 8'h80);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_onehot", oh[0], 8'h00);
    chk("s4_rst_seg", sg[0], 8'hFF);
    chk("s4_rst_seen", sn[0], 8'h00);
    do_reset();

    // HOLD=1, GAP=0 instance: codes 1 then 2
    code = 3'd1; valid = 1'b1;
    step();
    chk("s5_seq0", oh[1], 8'h02);
    code = 3'd2;
    step();
    chk("s5_seq1", oh[1], 8'h00);
    step();
    chk("s5_seq2", oh[1], 8'h04);
    valid = 1'b0;
    repeat (12) step();

    // Clear coinciding with an accept
    clr = 1'b1; code = 3'd0; valid = 1'b1;
    step();
    clr = 1'b0; valid = 1'b0;
    repeat (12) step();
    chk("s6_seen01", sn[0], 8'h01);
    clr = 1'b1; code = 3'd6; valid = 1'b1;
    step();
    chk("s6_seen40", sn[0], 8'h40);
    clr = 1'b0; valid = 1'b0;
    repeat (12) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      en    = ($urandom % 8) != 0;
      valid = ($urandom % 3) == 0;
      code  = 3'($urandom % 8);
      clr   = ($urandom % 16) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
